// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: upstream handshake + payload, downstream handshake + payload, status.
// slave is the stage's view, master is the driver/consumer view.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_zero_i;
  logic [DATA_W-1:0] store_data_i;
  logic [RD_W-1:0]   rd_i;
  logic [3:0]        ctrl_i;
  logic [DATA_W-1:0] br_target_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] alu_data_o;
  logic [DATA_W-1:0] store_data_o;
  logic [RD_W-1:0]   rd_o;
  logic [2:0]        ctrl_o;
  logic              br_taken_o;
  logic [DATA_W-1:0] br_target_o;
  logic [1:0]        occ_o;

  modport slave (
    input  flush_i, valid_i, alu_data_i, alu_zero_i, store_data_i, rd_i, ctrl_i, br_target_i, ready_i,
    output ready_o, valid_o, alu_data_o, store_data_o, rd_o, ctrl_o, br_taken_o, br_target_o, occ_o
  );

  modport master (
    output flush_i, valid_i, alu_data_i, alu_zero_i, store_data_i, rd_i, ctrl_i, br_target_i, ready_i,
    input  ready_o, valid_o, alu_data_o, store_data_o, rd_o, ctrl_o, br_taken_o, br_target_o, occ_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register behind a 2-entry skid buffer with registered ready; resolves branches.
// Latency 1 cycle empty-to-valid; downstream stalls absorbed in the skid slot, never combinationally upstream.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input logic           clk_i,
  input logic           rst_i,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [RD_W-1:0]   rd;
    logic [2:0]        ctrl;
  } entry_t;

  entry_t            in_ent;
  entry_t            main_q, main_d;
  entry_t            skid_q, skid_d;
  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              ready_q, ready_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;
  logic              accept, xfer;

  assign in_ent.alu  = bus.alu_data_i;
  assign in_ent.st   = bus.store_data_i;
  assign in_ent.rd   = bus.rd_i;
  assign in_ent.ctrl = bus.ctrl_i[2:0];

  // Flush dominates both handshakes.
  assign accept = bus.valid_i & ready_q & ~bus.flush_i;
  assign xfer   = main_vld_q & bus.ready_i & ~bus.flush_i;

  always_comb begin
    main_d      = main_q;
    main_vld_d  = main_vld_q;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    if (bus.flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || xfer) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = in_ent;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_ent;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
    // Ready for next cycle depends only on next occupancy, so ready_i never reaches ready_o combinationally.
    ready_d     = !(main_vld_d && skid_vld_d);
    br_taken_d  = accept & bus.ctrl_i[3] & bus.alu_zero_i;
    br_target_d = br_taken_d ? bus.br_target_i : br_target_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      ready_q     <= 1'b1;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      ready_q     <= ready_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.valid_o      = main_vld_q;
  assign bus.alu_data_o   = main_q.alu;
  assign bus.store_data_o = main_q.st;
  assign bus.rd_o         = main_q.rd;
  assign bus.ctrl_o       = main_q.ctrl;
  assign bus.br_taken_o   = br_taken_q;
  assign bus.br_target_o  = br_target_q;
  assign bus.occ_o        = {main_vld_q & skid_vld_q, main_vld_q ^ skid_vld_q};

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, streaming, back-pressure, branch, flush, simultaneous, mid-stream reset.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(32), .RD_W(5)) bus ();

  ex_mem_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c,
                       input logic z, input logic [31:0] tgt);
    bus.valid_i      = v;
    bus.alu_data_i   = d;
    bus.store_data_i = d + 32'h1000;
    bus.rd_i         = d[4:0];
    bus.ctrl_i       = c;
    bus.alu_zero_i   = z;
    bus.br_target_i  = tgt;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r, input logic [1:0] occ,
                           input logic [31:0] d);
    chk({tag, ".valid"}, {31'b0, bus.valid_o}, {31'b0, v});
    chk({tag, ".ready"}, {31'b0, bus.ready_o}, {31'b0, r});
    chk({tag, ".occ"},   {30'b0, bus.occ_o},   {30'b0, occ});
    if (v) chk({tag, ".data"}, bus.alu_data_o, d);
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);

    // Reset held two cycles
    rst = 1'b1;
    step();
    step();
    chk("rst.valid",  {31'b0, bus.valid_o},    32'd0);
    chk("rst.ready",  {31'b0, bus.ready_o},    32'd1);
    chk("rst.occ",    {30'b0, bus.occ_o},      32'd0);
    chk("rst.br",     {31'b0, bus.br_taken_o}, 32'd0);
    chk("rst.data",   bus.alu_data_o,          32'd0);
    chk("rst.target", bus.br_target_o,         32'd0);
    rst = 1'b0;

    // Stream 1..4 at full rate
    bus.ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 4'b0001, 1'b0, 32'h0);
      step();
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, i);
    end
    chk("stream.st",   bus.store_data_o,      32'h1004);
    chk("stream.rd",   {27'b0, bus.rd_o},     32'd4);
    chk("stream.ctrl", {29'b0, bus.ctrl_o},   32'd1);
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    step();
    chk_state("stream.drain", 1'b0, 1'b1, 2'd0, 32'h0);

    // Back-pressure: A to main, B to skid, C held upstream
    bus.ready_i = 1'b0;
    drive(1'b1, 32'hA, 4'b0010, 1'b0, 32'h0);
    step();
    chk_state("bp.a", 1'b1, 1'b1, 2'd1, 32'hA);
    drive(1'b1, 32'hB, 4'b0010, 1'b0, 32'h0);
    step();
    chk_state("bp.b", 1'b1, 1'b0, 2'd2, 32'hA);
    drive(1'b1, 32'hC, 4'b0010, 1'b0, 32'h0);
    step();
    chk_state("bp.hold", 1'b1, 1'b0, 2'd2, 32'hA);
    chk("bp.hold.st", bus.store_data_o, 32'h100A);
    bus.ready_i = 1'b1;
    step();
    chk_state("bp.outB", 1'b1, 1'b1, 2'd1, 32'hB);
    step();
    chk_state("bp.outC", 1'b1, 1'b1, 2'd1, 32'hC);
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    step();
    chk_state("bp.empty", 1'b0, 1'b1, 2'd0, 32'h0);

    // Branch taken, then not taken, then idle
    drive(1'b1, 32'h55, 4'b1000, 1'b1, 32'h100);
    step();
    chk("br.taken",  {31'b0, bus.br_taken_o}, 32'd1);
    chk("br.target", bus.br_target_o,         32'h100);
    chk("br.pass",   {31'b0, bus.valid_o},    32'd1);
    chk("br.ctrl",   {29'b0, bus.ctrl_o},     32'd0);
    drive(1'b1, 32'h56, 4'b1000, 1'b0, 32'h200);
    step();
    chk("br.nt",      {31'b0, bus.br_taken_o}, 32'd0);
    chk("br.nt.tgt",  bus.br_target_o,         32'h100);
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    step();
    chk("br.idle", {31'b0, bus.br_taken_o}, 32'd0);

    // Branch pulse under a downstream stall lasts exactly one cycle
    bus.ready_i = 1'b0;
    drive(1'b1, 32'h60, 4'b1000, 1'b1, 32'h300);
    step();
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    chk("brst.taken",  {31'b0, bus.br_taken_o}, 32'd1);
    chk("brst.target", bus.br_target_o,         32'h300);
    step();
    chk("brst.once", {31'b0, bus.br_taken_o}, 32'd0);
    chk_state("brst.held", 1'b1, 1'b1, 2'd1, 32'h60);

    // Flush with occ=2 and a taken-branch input pending
    drive(1'b1, 32'h61, 4'b0001, 1'b0, 32'h0);
    step();
    chk_state("fl.full", 1'b1, 1'b0, 2'd2, 32'h60);
    drive(1'b1, 32'h62, 4'b1000, 1'b1, 32'h400);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    chk_state("fl.after", 1'b0, 1'b1, 2'd0, 32'h0);
    chk("fl.nobr", {31'b0, bus.br_taken_o}, 32'd0);

    // Flush with ready_o=1: the same-cycle branch input must be dropped
    drive(1'b1, 32'h70, 4'b0001, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h71, 4'b1000, 1'b1, 32'h500);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    chk_state("fl1.after", 1'b0, 1'b1, 2'd0, 32'h0);
    chk("fl1.nobr",   {31'b0, bus.br_taken_o}, 32'd0);
    chk("fl1.target", bus.br_target_o,         32'h300);
    step();
    chk("fl1.idle", {31'b0, bus.valid_o}, 32'd0);

    // Simultaneous transfer and accept after skid drains
    bus.ready_i = 1'b0;
    drive(1'b1, 32'h31, 4'b0001, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h32, 4'b0001, 1'b0, 32'h0);
    step();
    chk_state("sim.full", 1'b1, 1'b0, 2'd2, 32'h31);
    bus.ready_i = 1'b1;
    drive(1'b1, 32'h33, 4'b0001, 1'b0, 32'h0);
    step();
    chk_state("sim.o32", 1'b1, 1'b1, 2'd1, 32'h32);
    step();
    chk_state("sim.o33", 1'b1, 1'b1, 2'd1, 32'h33);
    bus.ready_i = 1'b0;
    drive(1'b1, 32'h34, 4'b0001, 1'b0, 32'h0);
    step();
    chk_state("sim.skid", 1'b1, 1'b0, 2'd2, 32'h33);
    bus.ready_i = 1'b1;
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    step();
    chk_state("sim.o34", 1'b1, 1'b1, 2'd1, 32'h34);
    step();
    chk_state("sim.empty", 1'b0, 1'b1, 2'd0, 32'h0);

    // Reset mid-stream with occ=2 and flush also raised
    bus.ready_i = 1'b0;
    drive(1'b1, 32'h41, 4'b0001, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h42, 4'b1000, 1'b1, 32'h600);
    step();
    rst = 1'b1;
    bus.flush_i = 1'b1;
    step();
    rst = 1'b0;
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    chk_state("mrst", 1'b0, 1'b1, 2'd0, 32'h0);
    chk("mrst.data",   bus.alu_data_o,      32'd0);
    chk("mrst.target", bus.br_target_o,     32'd0);
    chk("mrst.ctrl",   {29'b0, bus.ctrl_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
